muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Parametrised iterative multiply/divide coprocessor for the execute stage; replaces inline mult/div logic.
//   Supports signed/unsigned MUL, MULH, DIV and REM; processes BPC bits per cycle.
//   Keeps a HI register that execute exposes as register 7; execute may also write HI.
// PARAMETERS
//   RV   16  operand/result width; legal values 16 or 32
//   BPC  1   bits retired per RUN cycle; legal values 1, 2, 4; must divide RV
// PORTS
//   clk       in   1   sole clock
//   reset_n   in   1   reset; asynchronous, active-low
//   start     in   1   launch op; sampled only while busy=0
//   op        in   2   00 MUL (low), 01 MULH (high), 10 DIV (quotient), 11 REM (remainder)
//   sgn       in   1   1 = a and b are two's-complement signed
//   a         in   RV  multiplicand / dividend; captured on accepted start
//   b         in   RV  multiplier / divisor; captured on accepted start
//   abort     in   1   flush (trap/interrupt); cancels in-flight op
//   hi_wr     in   1   load HI from hi_wdata
//   hi_wdata  in   RV  HI write data
//   busy      out  1   op in flight
//   done      out  1   one-cycle pulse; result and hi valid
//   result    out  RV  selected result; held until next done
//   hi        out  RV  companion half
// BEHAVIOUR
//   Clock and reset: one clock; reset is asynchronous and active-low.
//   Reset values: state IDLE; busy=0, done=0, result=0, hi=0, iteration counter=0.
//   N = RV/BPC. Timing is counted from cycle 0, the cycle in which start is accepted.
//   FSM states: IDLE, RUN, FIX, DONE.
//     IDLE -> RUN on start.
//     IDLE -> FIX on start when the op is a special case (see below).
//     RUN -> FIX after N cycles.
//     FIX -> DONE, then DONE -> IDLE.
//   Special cases go RUN-less: done in cycle 2.
//     Div by zero: quotient = all ones; remainder = a.
//     Signed overflow (a = 1<<(RV-1), b = all ones, sgn=1): quotient = a; remainder = 0.
//   Normal op: busy is high in cycles 1..N+1; done pulses in cycle N+2 with busy=0.
//   A new start may be accepted in the done cycle.
//   busy = state is RUN or FIX. A start while busy=1 is ignored, with no side effect.
//   Signed ops use magnitudes in RUN; FIX applies sign correction.
//     Product sign = a^b.
//     Quotient sign = a^b; remainder sign = sign of a.
//   MUL: shift-add on BPC multiplier bits per cycle, with a 2*RV product register.
//   DIV: restoring, BPC quotient bits per cycle, MSB first.
//   HI at done holds the companion half:
//     MUL  -> product[2RV-1:RV]
//     MULH -> product[RV-1:0]
//     DIV  -> remainder
//     REM  -> quotient
//   hi_wr rules:
//     Honoured only while IDLE or DONE, and not in a cycle with an accepted start.
//     Ignored while busy.
//     If hi_wr and done coincide, hi_wr wins: hi = hi_wdata next cycle; result is unaffected.
//   abort: in any state, next state is IDLE.
//     busy=0 next cycle; done is not pulsed; result and hi are unchanged.
//     abort together with start: the start is dropped.
//   reset_n low mid-op: all state clears immediately to reset values; no done.
//   Operands are captured at start; a and b may change freely afterwards.
//   result/hi are updated only on done (or by hi_wr for hi).
// TESTING
//   1) RV=16, BPC=1, MUL unsigned a=0x1234, b=0x0010 -> done at cycle 18; result=0x2340, hi=0x0001.
//   2) MULH signed a=0xFFFF, b=0x0002 -> result=0xFFFF, hi=0xFFFE; busy high cycles 1..17.
//   3) DIV signed a=0xFFF9 (-7), b=0x0002 -> result=0xFFFD, hi=0xFFFF; then REM on same operands -> result=0xFFFF, hi=0xFFFD.
//   4) DIV a=0x1234, b=0 -> done at cycle 2, result=0xFFFF, hi=0x1234.
//      DIV signed a=0x8000, b=0xFFFF -> done at cycle 2, result=0x8000, hi=0.
//   5) abort in cycle 5 of a DIV -> busy=0 at cycle 6, no done, hi unchanged.
//      start during busy -> ignored.
//      hi_wr=1, hi_wdata=0xBEEF in the done cycle -> hi=0xBEEF.
//   6) RV=32, BPC=4, MUL 0xFFFFFFFF*0xFFFFFFFF unsigned -> done at cycle 10; result=0x00000001, hi=0xFFFFFFFE.
//      reset_n low mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned MUL/MULH/DIV/REM, BPC bits per cycle: done at cycle RV/BPC+2, or 2 for div-by-zero/overflow.
// No backpressure: start is ignored while busy; abort flushes to IDLE with result and hi untouched.
module muldiv_unit #(
    parameter int RV  = 16,
    parameter int BPC = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic          sgn,
    input  logic [RV-1:0] a,
    input  logic [RV-1:0] b,
    input  logic          abort,
    input  logic          hi_wr,
    input  logic [RV-1:0] hi_wdata,
    output logic          busy,
    output logic          done,
    output logic [RV-1:0] result,
    output logic [RV-1:0] hi
);

    localparam int N  = RV / BPC;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t          state, state_nx;
    logic            accept;
    logic [CW-1:0]   cnt;
    logic [2*RV-1:0] acc, acc_step;
    logic [RV-1:0]   opnd;
    logic [1:0]      op_q;
    logic            neg_main, neg_rem;

    logic            a_neg, b_neg, special;
    logic [RV-1:0]   mag_a, mag_b;
    logic [RV:0]     sum, shl, diff;
    logic [2*RV-1:0] prod_fix;
    logic [RV-1:0]   quo_fix, rem_fix, res_nx, hi_nx;

    assign a_neg   = sgn & a[RV-1];
    assign b_neg   = sgn & b[RV-1];
    assign mag_a   = a_neg ? -a : a;
    assign mag_b   = b_neg ? -b : b;
    assign special = op[1] && ((b == '0) || (sgn && (a == {1'b1, {(RV-1){1'b0}}}) && (b == '1)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        busy     = (state == RUN) || (state == FIX);
        done     = (state == DONE);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = special ? FIX : RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN:     if (cnt == LAST) state_nx = FIX;
            FIX:     state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
            accept   = 1'b0;
        end
    end

    // acc holds {upper partial product, multiplier} for MUL, {remainder, dividend/quotient} for DIV.
    always_comb begin
        acc_step = acc;
        sum      = '0;
        shl      = '0;
        diff     = '0;
        for (int i = 0; i < BPC; i++) begin
            if (!op_q[1]) begin
                sum      = {1'b0, acc_step[2*RV-1:RV]} + (acc_step[0] ? {1'b0, opnd} : '0);
                acc_step = {sum, acc_step[RV-1:1]};
            end else begin
                shl  = {acc_step[2*RV-1:RV], acc_step[RV-1]};
                diff = shl - {1'b0, opnd};
                if (!diff[RV]) acc_step = {diff[RV-1:0], acc_step[RV-2:0], 1'b1};
                else           acc_step = {shl[RV-1:0],  acc_step[RV-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        prod_fix = neg_main ? -acc : acc;
        quo_fix  = neg_main ? -acc[RV-1:0] : acc[RV-1:0];
        rem_fix  = neg_rem  ? -acc[2*RV-1:RV] : acc[2*RV-1:RV];
        res_nx   = prod_fix[RV-1:0];
        hi_nx    = prod_fix[2*RV-1:RV];
        case (op_q)
            2'b01: begin res_nx = prod_fix[2*RV-1:RV]; hi_nx = prod_fix[RV-1:0]; end
            2'b10: begin res_nx = quo_fix;             hi_nx = rem_fix;          end
            2'b11: begin res_nx = rem_fix;             hi_nx = quo_fix;          end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            op_q     <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= '0;
            hi       <= '0;
        end else begin
            if (accept) begin
                op_q <= op;
                cnt  <= '0;
                // Special cases preload the final magnitudes so FIX passes them through untouched.
                if (!op[1]) begin
                    acc      <= {{RV{1'b0}}, mag_b};
                    opnd     <= mag_a;
                    neg_main <= a_neg ^ b_neg;
                    neg_rem  <= 1'b0;
                end else if (b == '0) begin
                    acc      <= {a, {RV{1'b1}}};
                    neg_main <= 1'b0;
                    neg_rem  <= 1'b0;
                end else if (special) begin
                    acc      <= {{RV{1'b0}}, a};
                    neg_main <= 1'b0;
                    neg_rem  <= 1'b0;
                end else begin
                    acc      <= {{RV{1'b0}}, mag_a};
                    opnd     <= mag_b;
                    neg_main <= a_neg ^ b_neg;
                    neg_rem  <= a_neg;
                end
            end else if (state == RUN && !abort) begin
                acc <= acc_step;
                cnt <= cnt + CW'(1);
            end

            if (state == FIX && !abort) result <= res_nx;

            if (hi_wr && (state == IDLE || state == DONE) && !accept)
                hi <= hi_wdata;
            else if (state == FIX && !abort)
                hi <= hi_nx;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit (RV=16/BPC=1 and RV=32/BPC=4) against an integer-arithmetic model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start16 = 1'b0, start32 = 1'b0;
    logic        hi_wr16 = 1'b0, hi_wr32 = 1'b0;
    logic        abort = 1'b0, sgn = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, hi_wdata = '0;

    logic        busy16, done16, busy32, done32;
    logic [15:0] res16, hi16;
    logic [31:0] res32, hi32;

    logic        sel = 1'b0;
    logic        cur_busy, cur_done;
    logic [31:0] cur_res, cur_hi;

    int          n_chk = 0, n_pass = 0;
    logic [31:0] last_res, last_hi;
    int          last_lat, seen;

    always #5 clk = ~clk;

    muldiv_unit #(.RV(16), .BPC(1)) u16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .op(op), .sgn(sgn),
        .a(a[15:0]), .b(b[15:0]), .abort(abort), .hi_wr(hi_wr16), .hi_wdata(hi_wdata[15:0]),
        .busy(busy16), .done(done16), .result(res16), .hi(hi16)
    );

    muldiv_unit #(.RV(32), .BPC(4)) u32 (
        .clk(clk), .reset_n(reset_n), .start(start32), .op(op), .sgn(sgn),
        .a(a), .b(b), .abort(abort), .hi_wr(hi_wr32), .hi_wdata(hi_wdata),
        .busy(busy32), .done(done32), .result(res32), .hi(hi32)
    );

    assign cur_busy = sel ? busy32 : busy16;
    assign cur_done = sel ? done32 : done16;
    assign cur_res  = sel ? res32 : {16'h0, res16};
    assign cur_hi   = sel ? hi32  : {16'h0, hi16};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Runs one op from a negedge where the selected unit is idle or in its done cycle;
    // returns at the negedge of the done cycle. noise pokes start/hi_wr while busy.
    task automatic do_op(input logic inst, input logic [1:0] o, input logic s,
                         input logic [31:0] x, input logic [31:0] y, input logic noise);
        int          w, c, lat_exp;
        logic [31:0] mask, xa, yb, q, r, lo, up, er, eh;
        longint      sa, sb;
        logic [63:0] pr;
        logic        busy_ok;
        w       = inst ? 32 : 16;
        mask    = inst ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        xa      = x & mask;
        yb      = y & mask;
        sa      = s ? (inst ? longint'($signed(xa)) : longint'($signed(xa[15:0]))) : longint'(xa);
        sb      = s ? (inst ? longint'($signed(yb)) : longint'($signed(yb[15:0]))) : longint'(yb);
        lat_exp = (inst ? 8 : 16) + 2;
        if (!o[1]) begin
            pr = sa * sb;
            lo = pr[31:0] & mask;
            up = 32'(pr >> w) & mask;
            er = o[0] ? up : lo;
            eh = o[0] ? lo : up;
        end else begin
            if (yb == 0) begin
                q = mask; r = xa; lat_exp = 2;
            end else if (s && xa == (32'h1 << (w - 1)) && yb == mask) begin
                q = xa; r = 0; lat_exp = 2;
            end else if (s) begin
                q = 32'(sa / sb) & mask;
                r = 32'(sa % sb) & mask;
            end else begin
                q = xa / yb;
                r = xa % yb;
            end
            er = o[0] ? r : q;
            eh = o[0] ? q : r;
        end

        sel = inst; op = o; sgn = s; a = x; b = y;
        if (inst) start32 = 1'b1; else start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0; start32 = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        c = 1;
        busy_ok = 1'b1;
        while (!cur_done && c < 60) begin
            if (!cur_busy) busy_ok = 1'b0;
            if (noise && c == 3) begin
                if (inst) start32 = 1'b1; else start16 = 1'b1;
            end
            if (noise && c == 4) begin
                hi_wdata = $urandom;
                if (inst) hi_wr32 = 1'b1; else hi_wr16 = 1'b1;
            end
            @(negedge clk);
            start16 = 1'b0; start32 = 1'b0; hi_wr16 = 1'b0; hi_wr32 = 1'b0;
            c++;
        end
        chk("latency", 64'(c), 64'(lat_exp));
        chk("busy_window", {busy_ok, cur_busy}, 2'b10);
        chk("result", cur_res, er);
        chk("hi", cur_hi, eh);
        last_res = cur_res;
        last_hi  = cur_hi;
        last_lat = c;
    endtask

    initial begin
        logic        inst, s;
        logic [1:0]  o;
        logic [31:0] x, y;
        int          kind;

        #1;
        chk("rst_ctl16", {busy16, done16}, 0);
        chk("rst_dat16", {res16, hi16}, 0);
        chk("rst_ctl32", {busy32, done32}, 0);
        chk("rst_dat32", {res32, hi32}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        do_op(1'b0, 2'b00, 1'b0, 32'h1234, 32'h0010, 1'b0);
        chk("t1_res", last_res, 32'h2340);
        chk("t1_hi", last_hi, 32'h0001);
        chk("t1_lat", 64'(last_lat), 18);
        do_op(1'b0, 2'b01, 1'b1, 32'hFFFF, 32'h0002, 1'b0);
        chk("t2_res", last_res, 32'hFFFF);
        chk("t2_hi", last_hi, 32'hFFFE);
        do_op(1'b0, 2'b10, 1'b1, 32'hFFF9, 32'h0002, 1'b0);
        chk("t3_div_res", last_res, 32'hFFFD);
        chk("t3_div_hi", last_hi, 32'hFFFF);
        do_op(1'b0, 2'b11, 1'b1, 32'hFFF9, 32'h0002, 1'b0);
        chk("t3_rem_res", last_res, 32'hFFFF);
        chk("t3_rem_hi", last_hi, 32'hFFFD);
        do_op(1'b0, 2'b10, 1'b0, 32'h1234, 32'h0000, 1'b0);
        chk("t4_dz_res", last_res, 32'hFFFF);
        chk("t4_dz_hi", last_hi, 32'h1234);
        chk("t4_dz_lat", 64'(last_lat), 2);
        do_op(1'b0, 2'b10, 1'b1, 32'h8000, 32'hFFFF, 1'b0);
        chk("t4_ovf_res", last_res, 32'h8000);
        chk("t4_ovf_hi", last_hi, 32'h0000);
        chk("t4_ovf_lat", 64'(last_lat), 2);

        hi_wdata = 32'hBEEF; hi_wr16 = 1'b1;
        @(negedge clk);
        hi_wr16 = 1'b0;
        chk("hiwr_done_hi", hi16, 16'hBEEF);
        chk("hiwr_done_res", res16, 16'h8000);
        chk("done_single", done16, 0);

        hi_wdata = 32'h1357; hi_wr16 = 1'b1;
        @(negedge clk);
        hi_wr16 = 1'b0;
        chk("hiwr_idle", hi16, 16'h1357);

        sel = 1'b0; op = 2'b10; sgn = 1'b0; a = 32'h1234; b = 32'h0003; start16 = 1'b1;
        @(negedge clk); start16 = 1'b0;
        repeat (2) @(negedge clk);
        hi_wdata = 32'hAAAA; hi_wr16 = 1'b1;
        @(negedge clk); hi_wr16 = 1'b0;
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_busy", busy16, 0);
        seen = 0;
        repeat (25) begin
            if (done16) seen++;
            @(negedge clk);
        end
        chk("abort_nodone", 64'(seen), 0);
        chk("abort_hi", hi16, 16'h1357);
        chk("abort_res", res16, 16'h8000);

        op = 2'b00; a = 32'h5; b = 32'h7; start16 = 1'b1; abort = 1'b1;
        @(negedge clk);
        start16 = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy16, 0);
        seen = 0;
        repeat (20) begin
            if (done16) seen++;
            @(negedge clk);
        end
        chk("start_abort_nodone", 64'(seen), 0);

        for (int i = 0; i < 80; i++) begin
            inst = 1'($urandom_range(0, 1));
            o    = 2'($urandom_range(0, 3));
            s    = 1'($urandom_range(0, 1));
            x    = $urandom;
            y    = $urandom;
            kind = $urandom_range(0, 7);
            case (kind)
                0: y = 32'h0;
                1: begin x = inst ? 32'h8000_0000 : 32'h8000; y = 32'hFFFF_FFFF; s = 1'b1; end
                2: y = 32'($urandom_range(1, 15));
                3: x = 32'($urandom_range(0, 20));
                4: y = 32'h1;
                default: ;
            endcase
            do_op(inst, o, s, x, y, 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) repeat (2) @(negedge clk);
        end

        do_op(1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("t6_res", last_res, 32'h0000_0001);
        chk("t6_hi", last_hi, 32'hFFFF_FFFE);
        chk("t6_lat", 64'(last_lat), 10);

        @(negedge clk);
        sel = 1'b1; op = 2'b00; sgn = 1'b0; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start32 = 1'b1;
        @(negedge clk); start32 = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ctl32", {busy32, done32}, 0);
        chk("arst_dat32", {res32, hi32}, 0);
        chk("arst_dat16", {res16, hi16}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (15) begin
            if (done32 || busy32) seen++;
            @(negedge clk);
        end
        chk("arst_quiet", 64'(seen), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
